systolic_column_cacc: RTL and testbench



---
 rtl/systolic_column_cacc.sv | 181 ++++++++++++++++++
 tb/tb_systolic_column_cacc.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_column_cacc.sv
// Per-pixel channel accumulator behind the systolic MAC column, with a valid/ready output FIFO.
// Optional: define CACC_SAT_EN for per-lane saturating adds (default wraps modulo 2^ACC_DW).
module systolic_column_cacc #(
  parameter int unsigned TOUT       = 8,
  parameter int unsigned PSUM_DW    = 20,
  parameter int unsigned ACC_DW     = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned LOG2_DEPTH = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LOG2_DEPTH:0]      cfg_wout_len,
  input  logic [15:0]              cfg_acc_num,
  input  logic                     start,
  input  logic                     psum_vld,
  input  logic [TOUT*PSUM_DW-1:0]  psum,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [TOUT*ACC_DW-1:0]   out_dat,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               err
);

  localparam int unsigned FifoAw = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = FifoAw + 1;
  localparam int unsigned LenW   = LOG2_DEPTH + 1;

  typedef enum logic [1:0] {StIdle, StAcc, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [LenW-1:0]         wlen_q, wlen_d;
  logic [15:0]             anum_q, anum_d;
  logic [LOG2_DEPTH-1:0]   pix_q, pix_d;
  logic [15:0]             pass_q, pass_d;
  logic                    done_q, done_d;
  logic [1:0]              err_q, err_d;
  logic [FifoAw-1:0]       rd_q, rd_d, wr_q, wr_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic [TOUT*ACC_DW-1:0]  bank [DEPTH];
  logic [TOUT*ACC_DW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [TOUT*ACC_DW-1:0]  acc_val;

  logic beat, first_pass, last_pass, last_pix, pop, full, push_req, push, bank_we;

  // First pass ignores the stale bank entry; later passes add with wrap or saturation.
  function automatic logic [ACC_DW-1:0] lane_next(input logic [ACC_DW-1:0]  prev,
                                                 input logic [PSUM_DW-1:0] p,
                                                 input logic               first);
    logic [ACC_DW-1:0] ext;
    logic [ACC_DW:0]   sum;
    logic [ACC_DW-1:0] res;
    ext = ACC_DW'($signed(p));
    sum = {prev[ACC_DW-1], prev} + {ext[ACC_DW-1], ext};
    res = sum[ACC_DW-1:0];
`ifdef CACC_SAT_EN
    if (sum[ACC_DW] != sum[ACC_DW-1]) begin
      res = sum[ACC_DW] ? {1'b1, {(ACC_DW-1){1'b0}}} : {1'b0, {(ACC_DW-1){1'b1}}};
    end
`endif
    if (first) res = ext;
    return res;
  endfunction

  assign beat       = (state_q == StAcc) && psum_vld;
  assign first_pass = (pass_q == 16'd0);
  assign last_pass  = (pass_q == anum_q - 16'd1);
  assign last_pix   = ({1'b0, pix_q} == wlen_q - LenW'(1));
  assign out_vld    = (cnt_q != '0);
  assign pop        = out_vld && out_rdy;
  assign full       = (cnt_q == CntW'(FIFO_DEPTH));
  assign push_req   = beat && last_pass;
  assign push       = push_req && (!full || pop);
  assign bank_we    = beat && !last_pass;

  assign out_dat = out_vld ? fifo_mem[rd_q] : '0;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign err     = err_q;

  always_comb begin
    acc_val = '0;
    for (int i = 0; i < TOUT; i++) begin
      acc_val[i*ACC_DW +: ACC_DW] = lane_next(bank[pix_q][i*ACC_DW +: ACC_DW],
                                              psum[i*PSUM_DW +: PSUM_DW], first_pass);
    end
  end

  always_comb begin
    state_d = state_q;
    wlen_d  = wlen_q;
    anum_d  = anum_q;
    pix_d   = pix_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAcc;
          pix_d   = '0;
          pass_d  = '0;
          err_d   = '0;
          if (cfg_wout_len == '0)                wlen_d = LenW'(1);
          else if (cfg_wout_len > LenW'(DEPTH))  wlen_d = LenW'(DEPTH);
          else                                   wlen_d = cfg_wout_len;
          anum_d  = (cfg_acc_num == 16'd0) ? 16'd1 : cfg_acc_num;
        end
      end
      StAcc: begin
        if (beat) begin
          if (last_pix) begin
            pix_d = '0;
            if (last_pass) begin
              state_d = StDrain;
              pass_d  = '0;
            end else begin
              pass_d = pass_q + 16'd1;
            end
          end else begin
            pix_d = pix_q + LOG2_DEPTH'(1);
          end
        end
      end
      StDrain: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (psum_vld && (state_q != StAcc)) err_d[1] = 1'b1;
    if (push_req && full && !pop)       err_d[0] = 1'b1;
  end

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop)  rd_d = rd_q + FifoAw'(1);
    if (push) wr_d = wr_q + FifoAw'(1);
    if (push && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (!push && pop) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wlen_q  <= '0;
      anum_q  <= '0;
      pix_q   <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wlen_q  <= wlen_d;
      anum_q  <= anum_d;
      pix_q   <= pix_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage arrays carry no reset; pointers and counts define what is live.
  always_ff @(posedge clk) begin
    if (bank_we) bank[pix_q] <= acc_val;
    if (push)    fifo_mem[wr_q] <= acc_val;
  end

endmodule

// File: tb/tb_systolic_column_cacc.sv
// Scoreboard bench for systolic_column_cacc: randomized jobs against a per-pixel sum model,
// plus a narrow 20-bit instance for the wrap/saturation boundary.
module tb_systolic_column_cacc;
  localparam int TOUT = 8, PSUM_DW = 20, ACC_DW = 32, DEPTH = 64, LOG2_DEPTH = 6, FIFO_DEPTH = 4;
  localparam longint MAXV = (64'sd1 <<< (ACC_DW - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (ACC_DW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [LOG2_DEPTH:0] cfg_wout_len = '0;
  logic [15:0] cfg_acc_num = '0;
  logic start = 1'b0, psum_vld = 1'b0;
  logic [TOUT*PSUM_DW-1:0] psum = '0;
  logic out_vld, busy, done;
  logic out_rdy = 1'b1;
  logic [TOUT*ACC_DW-1:0] out_dat;
  logic [1:0] err;

  // Narrow instance signals
  logic [2:0] w_len = 3'd1;
  logic [15:0] w_anum = 16'd2;
  logic w_start = 1'b0, w_vld = 1'b0, w_out_vld, w_busy, w_done;
  logic [19:0] w_psum = '0, w_out_dat;
  logic [1:0] w_err;

  int checks = 0, failures = 0, done_cnt = 0;
  bit rdy_force = 1'b0, rdy_val = 1'b1, stall_prev = 1'b0;
  logic [TOUT*ACC_DW-1:0] exp_q[$];
  logic [TOUT*ACC_DW-1:0] mon_exp, held_dat;

  systolic_column_cacc #(.TOUT(TOUT), .PSUM_DW(PSUM_DW), .ACC_DW(ACC_DW), .DEPTH(DEPTH),
                         .LOG2_DEPTH(LOG2_DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .cfg_wout_len(cfg_wout_len), .cfg_acc_num(cfg_acc_num),
    .start(start), .psum_vld(psum_vld), .psum(psum), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_dat(out_dat), .busy(busy), .done(done), .err(err));

  systolic_column_cacc #(.TOUT(1), .PSUM_DW(20), .ACC_DW(20), .DEPTH(4), .LOG2_DEPTH(2),
                         .FIFO_DEPTH(4)) dut_w (
    .clk(clk), .rst(rst), .cfg_wout_len(w_len), .cfg_acc_num(w_anum), .start(w_start),
    .psum_vld(w_vld), .psum(w_psum), .out_vld(w_out_vld), .out_rdy(1'b1),
    .out_dat(w_out_dat), .busy(w_busy), .done(w_done), .err(w_err));

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reduce an exact integer sum to the accumulator's numeric range.
  function automatic longint fix(input longint x);
    longint m;
`ifdef CACC_SAT_EN
    m = (x > MAXV) ? MAXV : ((x < MINV) ? MINV : x);
`else
    m = x & ((64'sd1 <<< ACC_DW) - 1);
    if (m > MAXV) m -= (64'sd1 <<< ACC_DW);
`endif
    return m;
  endfunction

  function automatic longint gen_lane(input int mode, input int pix, input int lane);
    logic [PSUM_DW-1:0] r;
    r = PSUM_DW'($urandom);
    case (mode)
      0: return 5;
      2: return (lane != 0) ? 0 : ((pix == 0) ? -7 : 9);
      default: return longint'($signed(r));
    endcase
  endfunction

  // hold < 0: free-running ready; otherwise ready held low until beat index 'hold'.
  task automatic run_job(input int cfg_w, input int cfg_a, input int mode, input int hold,
                         input int gap);
    int wl, an, beat_i, prev_done, t;
    bit exp_drop;
    longint acc[DEPTH][TOUT];
    logic [TOUT*PSUM_DW-1:0] pv;
    logic [TOUT*ACC_DW-1:0] ev;
    wl = (cfg_w == 0) ? 1 : ((cfg_w > DEPTH) ? DEPTH : cfg_w);
    an = (cfg_a == 0) ? 1 : cfg_a;
    prev_done = done_cnt;
    exp_drop = 1'b0;
    beat_i = 0;
    if (hold >= 0) begin
      rdy_force = 1'b1;
      rdy_val = 1'b0;
    end
    cfg_wout_len = (LOG2_DEPTH+1)'(cfg_w);
    cfg_acc_num = 16'(cfg_a);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int p = 0; p < an; p++) begin
      for (int x = 0; x < wl; x++) begin
        while (gap > 0 && $urandom_range(0, gap) != 0) begin
          psum_vld = 1'b0;
          @(posedge clk); #1;
        end
        for (int l = 0; l < TOUT; l++) begin
          longint v;
          v = gen_lane(mode, x, l);
          pv[l*PSUM_DW +: PSUM_DW] = PSUM_DW'(v);
          acc[x][l] = (p == 0) ? v : fix(acc[x][l] + v);
          ev[l*ACC_DW +: ACC_DW] = ACC_DW'(acc[x][l]);
        end
        if (hold >= 0 && beat_i == hold) rdy_val = 1'b1;
        if (p == an - 1) begin
          if (hold < 0 || beat_i >= hold || exp_q.size() < FIFO_DEPTH) exp_q.push_back(ev);
          else exp_drop = 1'b1;
        end
        // A start mid-job must be ignored, along with whatever cfg it carries.
        start = (mode == 1 && beat_i == 1);
        if (start) begin
          cfg_wout_len = 7'd3;
          cfg_acc_num = 16'd1;
        end
        psum = pv;
        psum_vld = 1'b1;
        beat_i++;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    psum_vld = 1'b0;
    if (hold >= 0) rdy_val = 1'b1;
    t = 0;
    while (done_cnt == prev_done && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check("done_seen", longint'(done_cnt != prev_done), 1);
    @(posedge clk); #1;
    check("done_once", done_cnt, prev_done + 1);
    check("busy_after_done", busy, 0);
    check("outputs_left", exp_q.size(), 0);
    check("err_after_job", err, {1'b0, exp_drop});
    rdy_force = 1'b0;
  endtask

  task automatic check_reset();
    check("rst_out_vld", out_vld, 0);
    check("rst_out_dat", longint'(out_dat != '0), 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
  endtask

  // Ready driver: never lets more than two expected beats sit unreturned.
  always @(posedge clk) begin
    #2;
    if (rdy_force) out_rdy = rdy_val;
    else out_rdy = (exp_q.size() >= 2) || ($urandom_range(0, 3) != 0);
  end

  // Monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        check("busy_at_done", busy, 0);
      end
      if (stall_prev && out_vld) begin
        checks++;
        if (out_dat !== held_dat) begin
          failures++;
          $display("FAIL hold_stable: got %h expected %h", out_dat, held_dat);
        end
      end
      if (out_vld && out_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got %h expected none", out_dat);
        end else begin
          mon_exp = exp_q.pop_front();
          if (out_dat !== mon_exp) begin
            failures++;
            $display("FAIL out_dat: got %h expected %h", out_dat, mon_exp);
          end
        end
      end
      stall_prev = out_vld && !out_rdy;
      held_dat = out_dat;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();

    run_job(4, 3, 0, -1, 0);            // constant +5 over three passes
    run_job(2, 1, 2, -1, 0);            // sign extension, single pass
    run_job(8, 1, 1, 8, 0);             // ready low all pass: 4 kept, 4 dropped
    run_job(5, 1, 1, 4, 0);             // push and pop on a full FIFO

    // Stray beat while idle
    psum_vld = 1'b1;
    @(posedge clk); #1;
    psum_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_beat_err", err, 2);
    check("idle_beat_no_out", out_vld, 0);

    run_job(0, 0, 1, -1, 1);            // zero cfg treated as 1
    run_job(70, 2, 1, -1, 1);           // wout_len clamps to DEPTH
    for (int i = 0; i < 4; i++) run_job($urandom_range(1, 64), $urandom_range(1, 4), 1, -1, 2);

    // Reset mid-pass, then a clean run
    cfg_wout_len = 7'd4;
    cfg_acc_num = 16'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    psum_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    psum_vld = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset();
    run_job(4, 2, 1, -1, 0);

    // Narrow instance: 0x7FFFF + 0x7FFFF at 20 bits
    w_start = 1'b1;
    @(posedge clk); #1;
    w_start = 1'b0;
    w_psum = 20'h7FFFF;
    w_vld = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    w_vld = 1'b0;
    t = 0;
    while (!w_out_vld && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
`ifdef CACC_SAT_EN
    check("narrow_sum", w_out_dat, 20'h7FFFF);
`else
    check("narrow_sum", w_out_dat, 20'hFFFFE);
`endif
    t = 0;
    while (!w_done && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("narrow_done", w_done, 1);
    check("narrow_err", w_err, 0);
    @(posedge clk); #1;
    check("narrow_idle", w_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
